// File: rtl/sliding_window_gen_pkg.sv
// Shared sizing helpers for the sliding window generator: flat window width,
// counter/address widths and the row-major element index used on the output bus.
package sliding_window_gen_pkg;

  function automatic int win_flat_width(input int dw, input int w);
    return dw * w * w;
  endfunction

  // One extra code point so the column counter can sit at "line full"
  function automatic int col_cnt_width(input int img_width);
    return $clog2(img_width + 1);
  endfunction

  function automatic int row_cnt_width(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int elem_idx(input int r, input int c, input int w);
    return r * w + c;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buffer_ram.sv
// Simple dual-port line buffer, one clock, read-first, one-cycle registered read.
// Contents are deliberately not reset.
module line_buffer_ram #(
  parameter int P_DATA_WIDTH = 20,
  parameter int P_DEPTH      = 640,
  parameter int P_ADDR_WIDTH = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [P_ADDR_WIDTH-1:0] waddr,
  input  logic [P_DATA_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [P_ADDR_WIDTH-1:0] raddr,
  output logic [P_DATA_WIDTH-1:0] rdata
);

  logic [P_DATA_WIDTH-1:0] mem_r [P_DEPTH];

  // Write port and registered read port; a same-address read returns the old word
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Raster stream to P_WIN_SIZE x P_WIN_SIZE window generator: cascaded line buffers feed
// a shift array, one window per accepted pixel once the window lies fully inside the image.
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int P_DATA_WIDTH = 20,
  parameter int P_WIN_SIZE   = 9,
  parameter int P_IMG_WIDTH  = 640,
  parameter int P_IMG_HEIGHT = 512
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst_n,
  input  logic                                               i_v_sync,
  input  logic                                               i_h_sync,
  input  logic [P_DATA_WIDTH-1:0]                            i_data,
  output logic                                               o_v_sync,
  output logic                                               o_h_sync,
  output logic [win_flat_width(P_DATA_WIDTH, P_WIN_SIZE)-1:0] o_data
);

  localparam int DW   = P_DATA_WIDTH;
  localparam int W    = P_WIN_SIZE;
  localparam int FLAT = win_flat_width(DW, W);
  localparam int CW   = col_cnt_width(P_IMG_WIDTH);
  localparam int RW   = row_cnt_width(P_IMG_HEIGHT);
  localparam int AW   = addr_width(P_IMG_WIDTH);

  logic          h_gated_s;
  logic          h_prev_r;
  logic          h_fall_s;
  logic          accept_s;
  logic          valid_s;
  logic [CW-1:0] col_cnt_r;
  logic [RW-1:0] row_cnt_r;

  logic          accept_d_r;
  logic          valid_d_r;
  logic          v_d_r;
  logic [DW-1:0] pix_d_r;
  logic [AW-1:0] addr_d_r;

  logic [DW-1:0]   lb_rd_s   [W-1];
  logic [DW-1:0]   lb_wr_s   [W-1];
  logic [DW-1:0]   col_vec_s [W];
  logic [DW-1:0]   win_r     [W][W];
  logic [DW-1:0]   win_next_s[W][W];
  logic [FLAT-1:0] flat_s;

  assign h_gated_s = i_v_sync & i_h_sync;
  assign h_fall_s  = h_prev_r & ~h_gated_s;
  assign accept_s  = h_gated_s & (col_cnt_r < CW'(P_IMG_WIDTH));
  assign valid_s   = accept_s & (row_cnt_r >= RW'(W - 1)) & (col_cnt_r >= CW'(W - 1));

  // Column/row position; leaving the frame restarts row gating so stale lines never reach a window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt_r <= '0;
      row_cnt_r <= '0;
      h_prev_r  <= 1'b0;
    end else begin
      h_prev_r <= h_gated_s;
      if (!i_v_sync) begin
        col_cnt_r <= '0;
        row_cnt_r <= '0;
      end else if (h_fall_s) begin
        col_cnt_r <= '0;
        if (row_cnt_r != RW'(P_IMG_HEIGHT - 1)) begin
          row_cnt_r <= row_cnt_r + 1'b1;
        end
      end else if (accept_s) begin
        col_cnt_r <= col_cnt_r + 1'b1;
      end
    end
  end

  // Stage 1: align pixel, address and strobes with the line-buffer read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      accept_d_r <= 1'b0;
      valid_d_r  <= 1'b0;
      v_d_r      <= 1'b0;
      pix_d_r    <= '0;
      addr_d_r   <= '0;
    end else begin
      accept_d_r <= accept_s;
      valid_d_r  <= valid_s;
      v_d_r      <= i_v_sync;
      pix_d_r    <= i_data;
      addr_d_r   <= col_cnt_r[AW-1:0];
    end
  end

  for (genvar k = 0; k < W - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_wr_s[k] = pix_d_r;
    end else begin : g_next
      assign lb_wr_s[k] = lb_rd_s[k-1];
    end

    line_buffer_ram #(
      .P_DATA_WIDTH(DW),
      .P_DEPTH     (P_IMG_WIDTH),
      .P_ADDR_WIDTH(AW)
    ) u_lb (
      .clk  (i_clk),
      .we   (accept_d_r),
      .waddr(addr_d_r),
      .wdata(lb_wr_s[k]),
      .re   (accept_s),
      .raddr(col_cnt_r[AW-1:0]),
      .rdata(lb_rd_s[k])
    );
  end

  // Incoming column: oldest line on top, current pixel at the bottom
  always_comb begin
    col_vec_s      = '{default: '0};
    col_vec_s[W-1] = pix_d_r;
    for (int r = 0; r < W - 1; r++) begin
      col_vec_s[r] = lb_rd_s[W-2-r];
    end
  end

  // Window after this cycle's shift, also used directly as the output payload
  always_comb begin
    win_next_s = '{default: '0};
    flat_s     = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W - 1; c++) begin
        win_next_s[r][c] = win_r[r][c+1];
      end
      win_next_s[r][W-1] = col_vec_s[r];
    end
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        flat_s[elem_idx(r, c, W)*DW +: DW] = win_next_s[r][c];
      end
    end
  end

  // Window shift array advances once per accepted pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_r <= '{default: '0};
    end else if (accept_d_r) begin
      win_r <= win_next_s;
    end
  end

  // Stage 2: registered outputs, payload forced to zero between strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_v_sync <= 1'b0;
      o_h_sync <= 1'b0;
      o_data   <= '0;
    end else begin
      o_v_sync <= v_d_r;
      o_h_sync <= valid_d_r;
      o_data   <= valid_d_r ? flat_s : '0;
    end
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen (3x3 window, 16x12 image) with a line-history
// reference model that predicts every window and its strobe timing.
module tb_sliding_window_gen;

  localparam int DW   = 16;
  localparam int W    = 3;
  localparam int IW   = 16;
  localparam int IH   = 12;
  localparam int FLAT = DW * W * W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            v_sync;
  logic            h_sync;
  logic [DW-1:0]   data;
  logic            o_v_sync;
  logic            o_h_sync;
  logic [FLAT-1:0] o_data;

  int checks = 0;
  int errors = 0;

  // reference model state (owned by the stimulus process)
  logic [DW-1:0]   hist [W-1][IW];
  logic [DW-1:0]   cur  [IW];
  int              m_row;
  int              m_col;
  logic            m_hprev;
  logic            drv_valid;
  logic [FLAT-1:0] exp_mem [1024];
  int              wr_ptr = 0;
  logic            mon_en;

  // monitor state (owned by the monitor process)
  logic            vp1 = 1'b0, vp2 = 1'b0, hp1 = 1'b0, hp2 = 1'b0;
  int              rd_ptr = 0;
  int              mon_err = 0;
  int              strobe_cnt = 0;
  int              mon_kind = 0;
  logic [FLAT-1:0] mon_act = '0;
  logic [FLAT-1:0] mon_exp = '0;
  logic [FLAT-1:0] win_log [1024];

  sliding_window_gen #(
    .P_DATA_WIDTH(DW),
    .P_WIN_SIZE  (W),
    .P_IMG_WIDTH (IW),
    .P_IMG_HEIGHT(IH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_v_sync(v_sync),
    .i_h_sync(h_sync),
    .i_data  (data),
    .o_v_sync(o_v_sync),
    .o_h_sync(o_h_sync),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  // Cycle-by-cycle comparison of syncs, strobe timing and window payload against the model
  always @(negedge clk) begin
    if (!mon_en) begin
      vp1 = 1'b0; vp2 = 1'b0; hp1 = 1'b0; hp2 = 1'b0;
      rd_ptr = wr_ptr;
    end else begin
      if (o_v_sync !== vp2) begin
        mon_err++; mon_kind = 1; mon_act = FLAT'(o_v_sync); mon_exp = FLAT'(vp2);
      end
      if (o_h_sync !== hp2) begin
        mon_err++; mon_kind = 2; mon_act = FLAT'(o_h_sync); mon_exp = FLAT'(hp2);
      end
      if (o_h_sync === 1'b1) begin
        win_log[strobe_cnt % 1024] = o_data;
        strobe_cnt++;
        if (rd_ptr == wr_ptr) begin
          mon_err++; mon_kind = 3; mon_act = o_data; mon_exp = '0;
        end else begin
          if (o_data !== exp_mem[rd_ptr % 1024]) begin
            mon_err++; mon_kind = 4; mon_act = o_data; mon_exp = exp_mem[rd_ptr % 1024];
          end
          rd_ptr++;
        end
      end else if (o_data !== '0) begin
        mon_err++; mon_kind = 5; mon_act = o_data; mon_exp = '0;
      end
      vp2 = vp1; vp1 = v_sync;
      hp2 = hp1; hp1 = drv_valid;
    end
  end

  function automatic logic [DW-1:0] elem(input logic [FLAT-1:0] w, input int i);
    return w[i*DW +: DW];
  endfunction

  function automatic logic [FLAT-1:0] first_win(input int tag);
    int              vals [9];
    logic [FLAT-1:0] r;
    vals = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    r = '0;
    for (int i = 0; i < 9; i++) r[i*DW +: DW] = DW'(tag * 256 + vals[i]);
    return r;
  endfunction

  function automatic logic [DW-1:0] pix(input int tag, input int line, input int col);
    if (col >= IW) return DW'(16'hF00 + col);
    return DW'(tag * 256 + line * 16 + col);
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_hprev = 1'b0; drv_valid = 1'b0;
  endtask

  // Drive one cycle of input and advance the reference model
  task automatic drive(input logic v, input logic h, input logic [DW-1:0] d);
    logic            hg;
    logic [FLAT-1:0] w;
    v_sync = v; h_sync = h; data = d;
    hg = v & h;
    drv_valid = 1'b0;
    if (hg && m_col < IW) begin
      cur[m_col] = d;
      if (m_row >= W - 1 && m_col >= W - 1) begin
        drv_valid = 1'b1;
        w = '0;
        for (int r = 0; r < W; r++) begin
          for (int c = 0; c < W; c++) begin
            if (r < W - 1) w[(r*W+c)*DW +: DW] = hist[r][m_col-W+1+c];
            else           w[(r*W+c)*DW +: DW] = cur[m_col-W+1+c];
          end
        end
        exp_mem[wr_ptr % 1024] = w;
        wr_ptr++;
      end
    end
    if (!v) begin
      m_row = 0; m_col = 0;
    end else if (m_hprev && !hg) begin
      m_col = 0;
      if (m_row < IH - 1) m_row++;
      for (int k = 0; k < W - 2; k++) hist[k] = hist[k+1];
      hist[W-2] = cur;
    end else if (hg && m_col < IW) begin
      m_col++;
    end
    m_hprev = hg;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int line, input int npix, input int tag, input int gap, input int abort_at);
    for (int c = 0; c < npix; c++) begin
      if (c == abort_at) begin
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, pix(tag, line, c));
        return;
      end
      drive(1'b1, 1'b1, pix(tag, line, c));
    end
    for (int g = 0; g < gap; g++) drive(1'b1, 1'b0, '0);
  endtask

  task automatic frame_end();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic frame(input int nlines, input int gap, input int tag, input int long_line);
    drive(1'b1, 1'b0, '0);
    for (int l = 0; l < nlines; l++) send_line(l, (l == long_line) ? 20 : IW, tag, gap, -1);
    frame_end();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i[0], i[1], DW'(i * 37));
      checks++;
      if ({o_v_sync, o_h_sync, o_data} !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got v=%b h=%b data=%h, expected all zero", i, o_v_sync, o_h_sync, o_data);
      end
    end
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0);
    checks++;
    if ({o_v_sync, o_h_sync, o_data} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got v=%b h=%b data=%h, expected all zero", o_v_sync, o_h_sync, o_data);
    end
  endtask

  task automatic check_frame(input string name, input int base, input int e0, input int n,
                             input logic [FLAT-1:0] first, input int last8);
    checks++;
    if (strobe_cnt - base !== n) begin
      errors++;
      $display("FAIL %s_strobes: got %0d, expected %0d", name, strobe_cnt - base, n);
    end
    checks++;
    if (win_log[base % 1024] !== first) begin
      errors++;
      $display("FAIL %s_first_win: got %h, expected %h", name, win_log[base % 1024], first);
    end
    checks++;
    if (elem(win_log[(base + n - 1) % 1024], 8) !== DW'(last8)) begin
      errors++;
      $display("FAIL %s_last_e8: got %0d, expected %0d", name, elem(win_log[(base + n - 1) % 1024], 8), last8);
    end
    checks++;
    if (mon_err - e0 !== 0) begin
      errors++;
      $display("FAIL %s_model: %0d mismatches (expected 0), kind %0d got %h want %h",
               name, mon_err - e0, mon_kind, mon_act, mon_exp);
    end
  endtask

  task automatic test_ramp();
    int base = strobe_cnt;
    int e0 = mon_err;
    frame(IH, 2, 0, -1);
    check_frame("ramp", base, e0, 140, first_win(0), 191);
    checks++;
    if (elem(win_log[(base + 139) % 1024], 0) !== DW'(157)) begin
      errors++;
      $display("FAIL ramp_last_e0: got %0d, expected 157", elem(win_log[(base + 139) % 1024], 0));
    end
  endtask

  task automatic test_row_saturation();
    int base = strobe_cnt;
    int e0 = mon_err;
    frame(18, 1, 0, -1);
    check_frame("long_frame", base, e0, 224, first_win(0), 287);
  endtask

  task automatic test_blanking();
    int gaps [2];
    gaps = '{1, 100};
    for (int g = 0; g < 2; g++) begin
      int base = strobe_cnt;
      int e0 = mon_err;
      frame(IH, gaps[g], 0, -1);
      check_frame((g == 0) ? "gap1" : "gap100", base, e0, 140, first_win(0), 191);
    end
  endtask

  task automatic test_overlong();
    int base = strobe_cnt;
    int e0 = mon_err;
    int idx [4];
    int exp8 [4];
    idx  = '{14, 27, 28, 29};
    exp8 = '{50, 63, 66, 67};
    frame(IH, 2, 0, 3);
    check_frame("overlong", base, e0, 140, first_win(0), 191);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (elem(win_log[(base + idx[i]) % 1024], 8) !== DW'(exp8[i])) begin
        errors++;
        $display("FAIL overlong_win%0d_e8: got %0d, expected %0d", idx[i],
                 elem(win_log[(base + idx[i]) % 1024], 8), exp8[i]);
      end
    end
    checks++;
    if (elem(win_log[(base + 28) % 1024], 0) !== DW'(32)) begin
      errors++;
      $display("FAIL overlong_line4_e0: got %0d, expected 32", elem(win_log[(base + 28) % 1024], 0));
    end
  endtask

  task automatic test_abort();
    int base = strobe_cnt;
    int e0 = mon_err;
    int bad = 0;
    drive(1'b1, 1'b0, '0);
    for (int l = 0; l < 5; l++) send_line(l, IW, 1, 2, -1);
    send_line(5, IW, 1, 2, 8);
    frame_end();
    checks++;
    if (strobe_cnt - base !== 48) begin
      errors++;
      $display("FAIL abort_strobes: got %0d, expected 48", strobe_cnt - base);
    end
    base = strobe_cnt;
    frame(IH, 2, 2, -1);
    check_frame("after_abort", base, e0, 140, first_win(2), 2 * 256 + 191);
    for (int s = 0; s < 140; s++) begin
      for (int i = 0; i < 9; i++) begin
        if ((elem(win_log[(base + s) % 1024], i) >> 8) != 2) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_stale_pixels: got %0d foreign elements, expected 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int base;
    int e0 = mon_err;
    drive(1'b1, 1'b0, '0);
    for (int l = 0; l < 4; l++) send_line(l, IW, 3, 2, -1);
    for (int c = 0; c < 6; c++) drive(1'b1, 1'b1, pix(3, 4, c));
    checks++;
    if (o_h_sync !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_strobe: got %b, expected 1", o_h_sync);
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({o_v_sync, o_h_sync, o_data} !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b h=%b data=%h, expected all zero", o_v_sync, o_h_sync, o_data);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, '0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    base = strobe_cnt;
    for (int l = 0; l < 6; l++) send_line(l, IW, 1, 2, -1);
    frame_end();
    check_frame("areset", base, e0, 56, first_win(1), 256 + 5 * 16 + 15);
  endtask

  initial begin
    v_sync = 1'b0;
    h_sync = 1'b0;
    data = '0;
    mon_en = 1'b0;
    model_reset();
    test_reset();
    test_ramp();
    test_row_saturation();
    test_blanking();
    test_overlong();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
